// File: rtl/seq_detector_param_if.sv
// seq_detector_param_if: serial stream, control and match signals of the sequence detector
//   x, in_valid    serial data bit and its qualifier (master -> slave)
//   overlap_en     1 = overlapping detection, 0 = non-overlapping (master -> slave)
//   cnt_clr        synchronous clear of match_count (master -> slave)
//   z              registered match flag (slave -> master)
//   match_count    saturating match count, CNT_W bits (slave -> master)
interface seq_detector_param_if #(
   parameter int CNT_W = 8
);
   logic             x;
   logic             in_valid;
   logic             overlap_en;
   logic             cnt_clr;
   logic             z;
   logic [CNT_W-1:0] match_count;
   modport master (output x, in_valid, overlap_en, cnt_clr, input z, match_count);
   modport slave (input x, in_valid, overlap_en, cnt_clr, output z, match_count);
endinterface

// File: rtl/seq_detector_param.sv
// seq_detector_param: Moore serial detector for a PAT_W-bit PATTERN, first bit received is PATTERN[PAT_W-1]
//   clk     rising-edge clock
//   reset   synchronous active-high reset
//   bus     seq_detector_param_if.slave: x, in_valid, overlap_en, cnt_clr in; z, match_count out
//   Define SEQ_DET_COUNT_EN to build the saturating match counter; otherwise match_count is 0
module seq_detector_param #(
   parameter int               PAT_W   = 4,
   parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
   parameter int               CNT_W   = 8
) (
   input logic                 clk,
   input logic                 reset,
   seq_detector_param_if.slave bus
);
   localparam int SW = $clog2(PAT_W + 1);
   localparam int NE = 2 ** (SW + 1);

   function automatic logic pat_bit(int i);
      return |(PATTERN & (PAT_W'(1) << i));
   endfunction

   // Longest prefix of PATTERN that is a suffix of (first k pattern bits, then b)
   function automatic logic [SW-1:0] fallback(int k, logic b);
      logic [SW-1:0] r = '0;
      logic          ok;
      logic          sb;
      int            p;
      for (int l = 1; l <= PAT_W; l++) begin
         if (l <= k + 1) begin
            ok = 1'b1;
            for (int j = 0; j < l; j++) begin
               p  = k + 1 - l + j;
               sb = (p == k) ? b : pat_bit(PAT_W - 1 - p);
               if (sb != pat_bit(PAT_W - 1 - j)) ok = 1'b0;
            end
            if (ok) r = SW'(l);
         end
      end
      return r;
   endfunction

   // Entry {k, b} holds the next state; unreachable codes fall back to state 0
   function automatic logic [NE*SW-1:0] build();
      logic [NE*SW-1:0] t = '0;
      for (int k = 0; k <= PAT_W; k++)
         for (int b = 0; b < 2; b++)
            t[(2 * k + b) * SW +: SW] = fallback(k, 1'(b));
      return t;
   endfunction

   localparam logic [NE*SW-1:0] TBL = build();

   logic [SW-1:0] state;
   logic [SW-1:0] nxt;

   // Non-overlapping exit from a full match restarts as if from state 0
   always_comb
      nxt = (state == SW'(PAT_W) && !bus.overlap_en) ? TBL[{{SW{1'b0}}, bus.x} * SW +: SW]
                                                     : TBL[{state, bus.x} * SW +: SW];

   always_ff @(posedge clk)
      if (reset) begin
         state <= '0;
         bus.z <= 1'b0;
      end else if (bus.in_valid) begin
         state <= nxt;
         bus.z <= nxt == SW'(PAT_W);
      end

`ifdef SEQ_DET_COUNT_EN
   always_ff @(posedge clk)
      if (reset || bus.cnt_clr)
         bus.match_count <= '0;
      else if (bus.in_valid && nxt == SW'(PAT_W) && !(&bus.match_count))
         bus.match_count <= bus.match_count + 1'b1;
`else
   logic unused_clr;
   assign unused_clr      = bus.cnt_clr;
   assign bus.match_count = '0;
`endif
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: directed scoreboard bench for seq_detector_param with PATTERN=1101, CNT_W=2
module tb_seq_detector_param;
   localparam int CW = 2;
`ifdef SEQ_DET_COUNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   typedef struct packed {
      logic          z;
      logic [CW-1:0] c;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   exp_t q[$];
   exp_t e;
   int   vecs = 0;
   int   errs = 0;

   always #5 clk = ~clk;

   seq_detector_param_if #(.CNT_W(CW)) bus ();

   seq_detector_param #(.PAT_W(4), .PATTERN(4'b1101), .CNT_W(CW)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always @(negedge clk)
      if (q.size() > 0) begin
         e = q.pop_front();
         vecs++;
         if (bus.z !== e.z || bus.match_count !== e.c) begin
            errs++;
            $display("FAIL vec%0d: z=%b count=%0d, expected z=%b count=%0d",
                     vecs, bus.z, bus.match_count, e.z, e.c);
         end
      end

   // x is randomised whenever the bit is not valid
   task automatic drv(input bit r, input bit xi, input bit vi, input bit oi, input bit ci,
                      input bit ez, input int ec);
      #1;
      reset          = r;
      bus.x          = vi ? xi : 1'($urandom_range(0, 1));
      bus.in_valid   = vi;
      bus.overlap_en = oi;
      bus.cnt_clr    = ci;
      @(posedge clk);
      q.push_back('{z: ez, c: CNT_ON ? CW'(ec) : '0});
   endtask

   initial begin
      reset = 1'b1; bus.x = 1'b0; bus.in_valid = 1'b0; bus.overlap_en = 1'b1; bus.cnt_clr = 1'b0;
      // reset with active stream
      drv(1,1,1,1,0,0,0); drv(1,0,1,1,0,0,0);
      // overlap: 1,1,0,1,1,0,1 then idle hold
      drv(0,1,1,1,0,0,0); drv(0,1,1,1,0,0,0); drv(0,0,1,1,0,0,0); drv(0,1,1,1,0,1,1);
      drv(0,1,1,1,0,0,1); drv(0,0,1,1,0,0,1); drv(0,1,1,1,0,1,2); drv(0,0,0,1,0,1,2);
      drv(1,0,0,1,0,0,0);
      // non-overlap: 1,1,0,1,1,0,1
      drv(0,1,1,0,0,0,0); drv(0,1,1,0,0,0,0); drv(0,0,1,0,0,0,0); drv(0,1,1,0,0,1,1);
      drv(0,1,1,0,0,0,1); drv(0,0,1,0,0,0,1); drv(0,1,1,0,0,0,1);
      drv(1,0,0,0,0,0,0);
      // non-overlap: 1,1,0,1,1,1,0,1
      drv(0,1,1,0,0,0,0); drv(0,1,1,0,0,0,0); drv(0,0,1,0,0,0,0); drv(0,1,1,0,0,1,1);
      drv(0,1,1,0,0,0,1); drv(0,1,1,0,0,0,1); drv(0,0,1,0,0,0,1); drv(0,1,1,0,0,1,2);
      drv(1,0,0,0,0,0,0);
      // valid gating: 1,1, gap of 3, 0,1, then hold for 2
      drv(0,1,1,1,0,0,0); drv(0,1,1,1,0,0,0);
      drv(0,0,0,1,0,0,0); drv(0,0,0,1,0,0,0); drv(0,0,0,1,0,0,0);
      drv(0,0,1,1,0,0,0); drv(0,1,1,1,0,1,1); drv(0,0,0,1,0,1,1); drv(0,0,0,1,0,1,1);
      drv(1,0,0,1,0,0,0);
      // mid-sequence reset: 1,1,0, reset, 1, then 1,1,0,1
      drv(0,1,1,1,0,0,0); drv(0,1,1,1,0,0,0); drv(0,0,1,1,0,0,0); drv(1,1,1,1,0,0,0);
      drv(0,1,1,1,0,0,0); drv(0,1,1,1,0,0,0); drv(0,1,1,1,0,0,0); drv(0,0,1,1,0,0,0);
      drv(0,1,1,1,0,1,1);
      drv(1,0,0,1,0,0,0);
      // saturation: 5 overlapping matches, then clear coincident with a match, then one more
      drv(0,1,1,1,0,0,0); drv(0,1,1,1,0,0,0); drv(0,0,1,1,0,0,0); drv(0,1,1,1,0,1,1);
      drv(0,1,1,1,0,0,1); drv(0,0,1,1,0,0,1); drv(0,1,1,1,0,1,2);
      drv(0,1,1,1,0,0,2); drv(0,0,1,1,0,0,2); drv(0,1,1,1,0,1,3);
      drv(0,1,1,1,0,0,3); drv(0,0,1,1,0,0,3); drv(0,1,1,1,0,1,3);
      drv(0,1,1,1,0,0,3); drv(0,0,1,1,0,0,3); drv(0,1,1,1,0,1,3);
      drv(0,1,1,1,0,0,3); drv(0,0,1,1,0,0,3); drv(0,1,1,1,1,1,0);
      drv(0,1,1,1,0,0,0); drv(0,0,1,1,0,0,0); drv(0,1,1,1,0,1,1);
      #1;
      bus.in_valid = 1'b0;
      bus.cnt_clr  = 1'b0;
      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      #1;
      if (q.size() != 0) begin
         errs++;
         $display("FAIL drain: %0d entries left, expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
